// File: rtl/swap_seq_pkg.sv
// Shared definitions for the swap request sequencer.
// - Default parameter values for the sequencer and its request buffer.
// - FSM state encoding (IDLE, ISSUE, WAIT), kept as plain localparams so that
//   older code which compares against raw state codes keeps working.
package swap_seq_pkg;

  localparam int unsigned DefAddressWidth = 7;
  localparam int unsigned DefFifoDepth    = 4;
  localparam int unsigned DefSwapCycles   = 3;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

endpackage

// File: rtl/swap_req_fifo.sv
// Request buffer for the swap sequencer: a circular FIFO with occupancy count.
// Ports:
//   clk, reset     - clock, asynchronous active-high reset (empties the FIFO)
//   push, wdata    - write request; ignored while full
//   pop, rdata     - read request; rdata shows the head entry combinationally
//   full, empty    - occupancy flags
//   count          - number of stored entries (0..depth)
module swap_req_fifo #(
  parameter int unsigned depth = 4,
  parameter int unsigned width = 14
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [width-1:0]         wdata,
  output logic [width-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(depth):0]   count
);

  localparam int unsigned PtrW = $clog2(depth);
  localparam logic [PtrW:0] FullCount = depth[PtrW:0];

  logic [width-1:0] mem_q [depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == FullCount);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  // Depth is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PtrW+1)'(1);
        2'b01:   count_q <= count_q - (PtrW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; entries are only visible between valid pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/swap_req_sequencer.sv
// Swap request sequencer: buffers (a, b) swap requests and issues them one at a
// time to a register file swap port, waiting swap_cycles after each start.
// Ports:
//   clk, reset              - clock, asynchronous active-high reset
//   req_valid, req_ready    - upstream handshake
//   req_addr_a, req_addr_b  - locations to exchange
//   address_a, address_b    - addresses presented to the register file
//   swap                    - one-cycle swap start pulse
//   skipped                 - one-cycle pulse when an a==b request is dropped
//   pending                 - buffered, unissued requests
//   busy                    - sequence in progress or requests pending
module swap_req_sequencer
  import swap_seq_pkg::*;
#(
  parameter int unsigned address_width = DefAddressWidth,
  parameter int unsigned fifo_depth    = DefFifoDepth,
  parameter int unsigned swap_cycles   = DefSwapCycles
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [address_width-1:0]      req_addr_a,
  input  logic [address_width-1:0]      req_addr_b,
  output logic [address_width-1:0]      address_a,
  output logic [address_width-1:0]      address_b,
  output logic                          swap,
  output logic                          skipped,
  output logic [$clog2(fifo_depth):0]   pending,
  output logic                          busy
);

  localparam int unsigned CntW = $clog2(swap_cycles + 1);

  logic [1:0]               state_q, state_d;
  logic [CntW-1:0]          counter_q, counter_d;
  logic [address_width-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic                     swap_q, swap_d, skipped_q, skipped_d;

  logic                     push, pop, full, empty;
  logic [address_width-1:0] head_a, head_b;

  // Reset empties the FIFO asynchronously, so full is low and req_ready high
  // during reset; the FIFO flops are held in reset, so nothing is accepted.
  assign req_ready = !full;
  assign push      = req_valid && req_ready;
  assign pop       = (state_q == IDLE) && !empty;

  swap_req_fifo #(
    .depth (fifo_depth),
    .width (2 * address_width)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata ({req_addr_a, req_addr_b}),
    .rdata ({head_a, head_b}),
    .full  (full),
    .empty (empty),
    .count (pending)
  );

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    addr_a_d  = addr_a_q;
    addr_b_d  = addr_b_q;
    skipped_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          if (head_a == head_b) begin
            skipped_d = 1'b1;
          end else begin
            addr_a_d = head_a;
            addr_b_d = head_b;
            state_d  = ISSUE;
          end
        end
      end
      ISSUE: begin
        state_d   = WAIT;
        counter_d = CntW'(swap_cycles);
      end
      WAIT: begin
        counter_d = counter_q - CntW'(1);
        if (counter_q == CntW'(1)) state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        counter_d = '0;
      end
    endcase
    // Registered Moore pulse: high for exactly the cycle spent in ISSUE.
    swap_d = (state_d == ISSUE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      counter_q <= '0;
      addr_a_q  <= '0;
      addr_b_q  <= '0;
      swap_q    <= 1'b0;
      skipped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      addr_a_q  <= addr_a_d;
      addr_b_q  <= addr_b_d;
      swap_q    <= swap_d;
      skipped_q <= skipped_d;
    end
  end

  assign address_a = addr_a_q;
  assign address_b = addr_b_q;
  assign swap      = swap_q;
  assign skipped   = skipped_q;
  assign busy      = (state_q != IDLE) || (pending != '0);

endmodule

// File: tb/tb_swap_req_sequencer.sv
// Directed bench for swap_req_sequencer (default parameters: 7-bit addresses,
// depth 4, swap_cycles 3) with a behavioural register file on the swap port.
module tb_swap_req_sequencer;

  logic       clk;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [6:0] req_addr_a, req_addr_b;
  logic [6:0] address_a, address_b;
  logic       swap, skipped;
  logic [2:0] pending;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Swap monitor / attached register file.
  logic [6:0] sw_a[$];
  logic [6:0] sw_b[$];
  int         sw_t[$];
  logic [7:0] regmem [128];
  logic [7:0] refmem [128];
  logic [7:0] tmp;

  swap_req_sequencer #(
    .address_width (7),
    .fifo_depth    (4),
    .swap_cycles   (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr_a (req_addr_a),
    .req_addr_b (req_addr_b),
    .address_a  (address_a),
    .address_b  (address_b),
    .swap       (swap),
    .skipped    (skipped),
    .pending    (pending),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (swap === 1'b1) begin
      sw_a.push_back(address_a);
      sw_b.push_back(address_b);
      sw_t.push_back(cyc);
      tmp = regmem[address_a];
      regmem[address_a] = regmem[address_b];
      regmem[address_b] = tmp;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    sw_a.delete();
    sw_b.delete();
    sw_t.delete();
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 60 && busy; n++) step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain: got busy=%0b expected 0", name, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_addr_a = '0; req_addr_b = '0;
    #2;
    step(); step();
    checks += 6;
    if (swap !== 1'b0) begin errors++; $display("FAIL rst_swap: got %0b expected 0", swap); end
    if (skipped !== 1'b0) begin errors++; $display("FAIL rst_skipped: got %0b expected 0", skipped); end
    if (pending !== 3'd0) begin errors++; $display("FAIL rst_pending: got %0d expected 0", pending); end
    if (address_a !== 7'd0 || address_b !== 7'd0) begin
      errors++; $display("FAIL rst_addr: got %0d/%0d expected 0/0", address_a, address_b);
    end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b expected 0", busy); end
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %0b expected 1", req_ready); end
    reset = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL rst_release: got busy=%0b ready=%0b expected 0/1", busy, req_ready);
    end
  endtask

  task automatic test_single();
    clear_mon();
    req_valid = 1'b1; req_addr_a = 7'd22; req_addr_b = 7'd28;
    step();
    req_valid = 1'b0;
    checks += 2;
    if (pending !== 3'd1) begin errors++; $display("FAIL single_pending: got %0d expected 1", pending); end
    if (swap !== 1'b0) begin errors++; $display("FAIL single_early_swap: got %0b expected 0", swap); end
    step();
    checks += 2;
    if (swap !== 1'b1) begin errors++; $display("FAIL single_swap: got %0b expected 1", swap); end
    if (address_a !== 7'd22 || address_b !== 7'd28) begin
      errors++; $display("FAIL single_addr: got %0d/%0d expected 22/28", address_a, address_b);
    end
    for (int k = 1; k <= 4; k++) begin
      step();
      checks += 3;
      if (swap !== 1'b0) begin errors++; $display("FAIL single_pulse_len k=%0d: got %0b expected 0", k, swap); end
      if (busy !== (k <= 3)) begin
        errors++; $display("FAIL single_busy k=%0d: got %0b expected %0b", k, busy, (k <= 3));
      end
      if (address_a !== 7'd22 || address_b !== 7'd28) begin
        errors++; $display("FAIL single_hold k=%0d: got %0d/%0d expected 22/28", k, address_a, address_b);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_addr_a = 7'(2 * i + 1); req_addr_b = 7'(2 * i + 2);
      step();
      if (i == 1) begin
        checks++;
        if (pending !== 3'd1) begin errors++; $display("FAIL b2b_push_pop: got %0d expected 1", pending); end
      end
    end
    req_valid = 1'b0;
    drain("b2b");
    checks++;
    if (sw_a.size() != 4) begin errors++; $display("FAIL b2b_count: got %0d expected 4", sw_a.size()); end
    for (int i = 0; i < 4 && i < sw_a.size(); i++) begin
      checks++;
      if (sw_a[i] !== 7'(2 * i + 1) || sw_b[i] !== 7'(2 * i + 2)) begin
        errors++; $display("FAIL b2b_order %0d: got %0d/%0d expected %0d/%0d", i, sw_a[i], sw_b[i], 2 * i + 1, 2 * i + 2);
      end
      if (i > 0) begin
        checks++;
        if (sw_t[i] - sw_t[i-1] != 5) begin
          errors++; $display("FAIL b2b_spacing %0d: got %0d expected 5", i, sw_t[i] - sw_t[i-1]);
        end
      end
    end
  endtask

  task automatic test_skip();
    clear_mon();
    req_valid = 1'b1; req_addr_a = 7'd15; req_addr_b = 7'd15;
    step();
    req_valid = 1'b0;
    step();
    checks += 3;
    if (skipped !== 1'b1) begin errors++; $display("FAIL skip_pulse: got %0b expected 1", skipped); end
    if (swap !== 1'b0) begin errors++; $display("FAIL skip_swap: got %0b expected 0", swap); end
    if (pending !== 3'd0) begin errors++; $display("FAIL skip_pending: got %0d expected 0", pending); end
    step();
    checks += 2;
    if (skipped !== 1'b0) begin errors++; $display("FAIL skip_len: got %0b expected 0", skipped); end
    if (sw_a.size() != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL skip_idle: got swaps=%0d busy=%0b expected 0/0", sw_a.size(), busy);
    end
  endtask

  task automatic test_full();
    logic [2:0] exp_p [7] = '{3'd4, 3'd4, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4};
    logic       exp_r [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    clear_mon();
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_addr_a = 7'(20 + i); req_addr_b = 7'(40 + i);
      step();
    end
    req_addr_a = 7'd25; req_addr_b = 7'd45;
    for (int k = 0; k < 7; k++) begin
      if (k > 0) step();
      if (k == 4) req_valid = 1'b0;
      checks++;
      if (pending !== exp_p[k] || req_ready !== exp_r[k]) begin
        errors++;
        $display("FAIL full_occ k=%0d: got pending=%0d ready=%0b expected %0d/%0b", k, pending, req_ready, exp_p[k], exp_r[k]);
      end
    end
    req_valid = 1'b0;
    drain("full");
    checks++;
    if (sw_a.size() != 6) begin errors++; $display("FAIL full_count: got %0d expected 6", sw_a.size()); end
    for (int i = 0; i < 6 && i < sw_a.size(); i++) begin
      checks++;
      if (sw_a[i] !== 7'(20 + i) || sw_b[i] !== 7'(40 + i)) begin
        errors++; $display("FAIL full_order %0d: got %0d/%0d expected %0d/%0d", i, sw_a[i], sw_b[i], 20 + i, 40 + i);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_addr_a = 7'(60 + i); req_addr_b = 7'(70 + i);
      step();
    end
    req_addr_a = 7'd64; req_addr_b = 7'd74;
    checks++;
    if (pending !== 3'd3 || busy !== 1'b1) begin
      errors++; $display("FAIL rmid_pre: got pending=%0d busy=%0b expected 3/1", pending, busy);
    end
    clear_mon();
    reset = 1'b1;
    #1;
    checks += 3;
    if (swap !== 1'b0 || pending !== 3'd0) begin
      errors++; $display("FAIL rmid_clear: got swap=%0b pending=%0d expected 0/0", swap, pending);
    end
    if (address_a !== 7'd0 || address_b !== 7'd0) begin
      errors++; $display("FAIL rmid_addr: got %0d/%0d expected 0/0", address_a, address_b);
    end
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL rmid_ready: got ready=%0b busy=%0b expected 1/0", req_ready, busy);
    end
    step();
    checks++;
    if (pending !== 3'd0) begin errors++; $display("FAIL rmid_no_accept: got %0d expected 0", pending); end
    reset = 1'b0; req_valid = 1'b0;
    for (int k = 0; k < 15; k++) step();
    checks++;
    if (sw_a.size() != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL rmid_after: got swaps=%0d busy=%0b expected 0/0", sw_a.size(), busy);
    end
  endtask

  task automatic test_random();
    int exp_sw = 0;
    int timeouts = 0;
    int bad = 0;
    logic [6:0] a, b;
    logic [7:0] t;
    bit acc;
    clear_mon();
    for (int i = 0; i < 128; i++) begin
      regmem[i] = 8'(i);
      refmem[i] = 8'(i);
    end
    for (int r = 0; r < 200; r++) begin
      a = 7'($urandom_range(0, 127));
      b = ($urandom_range(0, 7) == 0) ? a : 7'($urandom_range(0, 127));
      req_valid = 1'b1; req_addr_a = a; req_addr_b = b;
      acc = 1'b0;
      for (int w = 0; w < 50 && !acc; w++) begin
        acc = req_ready;
        step();
      end
      if (!acc) timeouts++;
      else if (a != b) begin
        exp_sw++;
        t = refmem[a]; refmem[a] = refmem[b]; refmem[b] = t;
      end
      req_valid = 1'b0;
      if ($urandom_range(0, 3) == 0) step();
    end
    drain("rand");
    checks++;
    if (timeouts != 0) begin errors++; $display("FAIL rand_accept: got %0d timeouts expected 0", timeouts); end
    checks++;
    if (sw_a.size() != exp_sw) begin
      errors++; $display("FAIL rand_swaps: got %0d expected %0d", sw_a.size(), exp_sw);
    end
    for (int i = 0; i < 128; i++) if (regmem[i] !== refmem[i]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rand_mem: got %0d differing words expected 0", bad); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_skip();
    test_full();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
